// File: rtl/pipe_stage_reg_if.sv
// Handshake/bus bundle for pipe_stage_reg: upstream inputs, registered
// outputs, sticky halt and performance counters.
interface pipe_stage_reg_if #(
   parameter int DATA_W   = 16,
   parameter int NUM_DATA = 4,
   parameter int CTRL_W   = 10,
   parameter int CNT_W    = 16
);
   logic                       stall;
   logic                       flush;
   logic                       in_valid;
   logic                       in_halt;
   logic [CTRL_W-1:0]          in_ctrl;
   logic [NUM_DATA*DATA_W-1:0] in_data;
   logic                       out_valid;
   logic                       out_halt;
   logic [CTRL_W-1:0]          out_ctrl;
   logic [NUM_DATA*DATA_W-1:0] out_data;
   logic                       halted;
   logic [CNT_W-1:0]           stall_cnt;
   logic [CNT_W-1:0]           flush_cnt;

   modport master (
      output stall, flush, in_valid, in_halt, in_ctrl, in_data,
      input  out_valid, out_halt, out_ctrl, out_data,
      input  halted, stall_cnt, flush_cnt
   );

   modport slave (
      input  stall, flush, in_valid, in_halt, in_ctrl, in_data,
      output out_valid, out_halt, out_ctrl, out_data,
      output halted, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall, flush and sticky halt.
// Define PIPE_STAGE_PERF_EN to build the saturating stall/flush counters.
module pipe_stage_reg #(
   parameter int DATA_W   = 16,
   parameter int NUM_DATA = 4,
   parameter int CTRL_W   = 10,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   pipe_stage_reg_if.slave  io_stage
);
   logic                       r_valid;
   logic                       r_halt;
   logic                       r_halted;
   logic [CTRL_W-1:0]          r_ctrl;
   logic [NUM_DATA*DATA_W-1:0] r_data;
   logic                       w_halt_in;

   assign w_halt_in = io_stage.in_valid & io_stage.in_halt;

   // Priority: flush > halted-hold > stall > load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid  <= 1'b0;
         r_halt   <= 1'b0;
         r_halted <= 1'b0;
         r_ctrl   <= '0;
         r_data   <= '0;
      end else if (io_stage.flush) begin
         r_valid  <= 1'b0;
         r_halt   <= 1'b0;
         r_halted <= 1'b0;
         r_ctrl   <= '0;
         r_data   <= '0;
      end else if (!r_halted && !io_stage.stall) begin
         r_valid  <= io_stage.in_valid;
         r_halt   <= w_halt_in;
         r_halted <= w_halt_in;
         r_ctrl   <= io_stage.in_valid ? io_stage.in_ctrl : '0;
         r_data   <= io_stage.in_data;
      end
   end

   assign io_stage.out_valid = r_valid;
   assign io_stage.out_halt  = r_halt;
   assign io_stage.out_ctrl  = r_ctrl;
   assign io_stage.out_data  = r_data;
   assign io_stage.halted    = r_halted;

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (io_stage.flush && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         if (io_stage.stall && !io_stage.flush && !r_halted
             && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign io_stage.stall_cnt = r_stall_cnt;
   assign io_stage.flush_cnt = r_flush_cnt;
`else
   assign io_stage.stall_cnt = {CNT_W{1'b0}};
   assign io_stage.flush_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus randomized traffic
// checked every cycle against an action-level reference model.
module tb_pipe_stage_reg;
   localparam int DATA_W   = 16;
   localparam int NUM_DATA = 4;
   localparam int CTRL_W   = 10;
   localparam int CNT_W    = 4;
   localparam int DW       = DATA_W * NUM_DATA;
`ifdef PIPE_STAGE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   localparam int CMAX = (1 << CNT_W) - 1;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   pipe_stage_reg_if #(
      .DATA_W(DATA_W), .NUM_DATA(NUM_DATA),
      .CTRL_W(CTRL_W), .CNT_W(CNT_W)
   ) bus ();

   pipe_stage_reg #(
      .DATA_W(DATA_W), .NUM_DATA(NUM_DATA),
      .CTRL_W(CTRL_W), .CNT_W(CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .io_stage (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference state
   typedef enum { A_FLUSH, A_HOLD, A_STALL, A_LOAD } act_e;
   bit            m_valid;
   bit            m_halt;
   bit            m_halted;
   bit [CTRL_W-1:0] m_ctrl;
   bit [DW-1:0]   m_data;
   int            m_sc;
   int            m_fc;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_halt = 0; m_halted = 0;
      m_ctrl = '0; m_data = '0; m_sc = 0; m_fc = 0;
   endtask

   task automatic model_edge();
      act_e a;
      if (bus.flush)      a = A_FLUSH;
      else if (m_halted)  a = A_HOLD;
      else if (bus.stall) a = A_STALL;
      else                a = A_LOAD;
      if (bus.flush && m_fc < CMAX) m_fc++;
      if (a == A_STALL && m_sc < CMAX) m_sc++;
      case (a)
         A_FLUSH: begin
            m_valid = 0; m_halt = 0; m_halted = 0;
            m_ctrl = '0; m_data = '0;
         end
         A_LOAD: begin
            m_valid  = bus.in_valid;
            m_data   = bus.in_data;
            m_ctrl   = bus.in_valid ? bus.in_ctrl : '0;
            m_halt   = bus.in_valid && bus.in_halt;
            m_halted = m_halt;
         end
         default: ;
      endcase
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".valid"}, 64'(bus.out_valid), 64'(m_valid));
      chk({tag, ".halt"}, 64'(bus.out_halt), 64'(m_halt));
      chk({tag, ".ctrl"}, 64'(bus.out_ctrl), 64'(m_ctrl));
      chk({tag, ".data"}, 64'(bus.out_data), 64'(m_data));
      chk({tag, ".halted"}, 64'(bus.halted), 64'(m_halted));
      chk({tag, ".scnt"}, 64'(bus.stall_cnt), PERF ? 64'(m_sc) : 64'd0);
      chk({tag, ".fcnt"}, 64'(bus.flush_cnt), PERF ? 64'(m_fc) : 64'd0);
      chk({tag, ".inv"},
          64'(!bus.out_valid && (bus.out_halt || bus.out_ctrl != '0)),
          64'd0);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic drive(input bit s, input bit f, input bit v,
                        input bit h, input bit [CTRL_W-1:0] c,
                        input bit [DW-1:0] d);
      bus.stall = s; bus.flush = f; bus.in_valid = v;
      bus.in_halt = h; bus.in_ctrl = c; bus.in_data = d;
   endtask

   function automatic bit [DW-1:0] rnd_data();
      return {$urandom, $urandom};
   endfunction

   initial begin
      int sc0;
      total = 0;
      bad   = 0;
      drive(0, 0, 0, 0, '0, '0);
      rst = 1'b1;
      model_reset();
      #2;
      check_all("rst");
      @(negedge clk);
      @(negedge clk);
      check_all("rst_hold");
      rst = 1'b0;

      // reset and load
      drive(0, 0, 1, 0, 10'h2A5, 64'h1111_2222_3333_BEEF);
      step("load");
      chk("load.ctrl_k", 64'(bus.out_ctrl), 64'h2A5);
      chk("load.lane0_k", 64'(bus.out_data[15:0]), 64'hBEEF);

      // stall holds for 3 cycles while inputs move
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 0, 10'(i + 5), rnd_data());
         step("stall");
      end
      chk("stall.lane0_k", 64'(bus.out_data[15:0]), 64'hBEEF);
      chk("stall.cnt_k", 64'(bus.stall_cnt), PERF ? 64'd3 : 64'd0);

      // stall+flush -> flush
      drive(1, 1, 1, 0, 10'h155, rnd_data());
      step("stflush");
      chk("stflush.valid_k", 64'(bus.out_valid), 64'd0);
      chk("stflush.fcnt_k", 64'(bus.flush_cnt), PERF ? 64'd1 : 64'd0);

      // bubble load keeps data, drops ctrl
      drive(0, 0, 0, 1, 10'h3FF, 64'hCAFE_F00D_1234_5678);
      step("bubble");
      chk("bubble.ctrl_k", 64'(bus.out_ctrl), 64'd0);
      chk("bubble.data_k", 64'(bus.out_data), 64'hCAFE_F00D_1234_5678);

      // halt is sticky against new valid loads
      drive(0, 0, 1, 1, 10'h0F0, 64'h0000_0000_0000_DEAD);
      step("hlt");
      sc0 = m_sc;
      for (int i = 0; i < 5; i++) begin
         drive(i[0], 0, 1, 0, 10'(i + 1), rnd_data());
         step("hlt_hold");
      end
      chk("hlt.halted_k", 64'(bus.halted), 64'd1);
      chk("hlt.data_k", 64'(bus.out_data), 64'h0000_0000_0000_DEAD);
      chk("hlt.scnt_k", 64'(bus.stall_cnt), PERF ? 64'(sc0) : 64'd0);
      drive(0, 1, 1, 0, '0, '0);
      step("hlt_flush");
      chk("hlt_flush.halted_k", 64'(bus.halted), 64'd0);

      // stall saturation
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 1, 0, 10'(i), rnd_data());
         step("sat");
      end
      chk("sat.scnt_k", 64'(bus.stall_cnt), PERF ? 64'(CMAX) : 64'd0);

      // async reset while HALTED
      drive(0, 0, 1, 1, 10'h011, 64'h77);
      step("pre_arst");
      chk("pre_arst.halted_k", 64'(bus.halted), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("arst");
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 1, 0, 10'h2C3, 64'h9999);
      step("post_arst");
      chk("post_arst.ctrl_k", 64'(bus.out_ctrl), 64'h2C3);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
               $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
               CTRL_W'($urandom), rnd_data());
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
